fp_writeback_arbiter: RTL and testbench
=======================================

# fp_writeback_arbiter

Sits between the FP result producers (load unit, single-cycle FP ALU, multi-cycle FPU div/sqrt) and the single write port of the floating-point register file. Each cycle it picks at most one result and drives the registered `wr_en`/`rd`/`data` triple into the register file. It buffers multi-cycle FPU results in a small FIFO and keeps a per-register pending-write scoreboard for the issue stage's hazard check.

## Interface
- `FLEN`, 32, result/data width.
- `FIFO_DEPTH`, 2, FPU result buffer entries (power of two, ≥2).
- `STARVE_LIMIT`, 4, cycles a non-empty FIFO head may lose arbitration before it is forced through.

- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ld_valid` / `ld_ready`  in/out  1/1  load result handshake; `ld_ready` is constant 1.
- `ld_rd`, `ld_data`  in  5/FLEN  load destination and data.
- `alu_valid` / `alu_ready`  in/out  1/1  single-cycle FP result handshake.
- `alu_rd`, `alu_data`  in  5/FLEN  ALU destination and data.
- `fpu_valid` / `fpu_ready`  in/out  1/1  multi-cycle FPU result handshake.
- `fpu_rd`, `fpu_data`  in  5/FLEN  FPU destination and data.
- `issue_en`, `issue_rd`  in  1/5  issue stage reserves destination `issue_rd`.
- `busy_o`  out  32  pending-write bit per FP register.
- `wr_en_o`, `wr_rd_o`, `wr_data_o`  out  1/5/FLEN  register file write port (registered).

## Operation
- A transfer happens on a posedge where `x_valid && x_ready`. Producers hold their payload until the transfer.
- FPU results always go into the FIFO. `fpu_ready = !full`. An enqueue and a dequeue in the same cycle are legal when full, but `fpu_ready` still reads 0 then, so no combinational full-bypass.
- Grant each cycle, highest first:
  - Load, when `ld_valid`.
  - FIFO head, when the FIFO is non-empty and `starve_cnt == STARVE_LIMIT`.
  - ALU, when `alu_valid`.
  - FIFO head, when non-empty.
- `alu_ready = !ld_valid && !(starve_force)`. ALU is the only source that can be back-pressured by priority.
- `starve_cnt` is 0..STARVE_LIMIT, saturating:
  - Increments when the FIFO is non-empty and the head is not granted.
  - Clears on a head dequeue or when the FIFO is empty.
  - At the limit with `ld_valid`=1, the load still wins and the head waits. The counter stays saturated.
- Granted result at posedge N sets `wr_en_o`=1 and `wr_rd_o`/`wr_data_o` to that result through cycle N+1. With no grant, `wr_en_o`=0 and rd/data hold their last values.
- Scoreboard:
  - `issue_en` sets `busy_o[issue_rd]`.
  - A grant clears `busy_o[granted rd]` at the same posedge.
  - If set and clear hit the same index in one cycle, set wins.
  - f0 is an ordinary register with no special case.
- No ordering between sources is enforced. The issue stage must not reissue to a busy rd (WAW).

## Timing
- Reset values: `wr_en_o`=0, `wr_rd_o`=0, `wr_data_o`=0, `busy_o`=0, FIFO empty, `starve_cnt`=0, `fpu_ready`=1, `alu_ready`=!ld_valid.
- Latency is 1 cycle from transfer posedge to `wr_en_o`. The register file captures on the following negedge, so a result is readable from the register file one cycle after transfer.
- FIFO path adds ≥1 cycle: FPU transfer at N allows grant at the earliest at N+1, then write in N+2.
- `busy_o` clears on the grant edge, i.e. half a cycle before the register file write. Issue logic checking busy at N+1 reads the value written at negedge of N+1 through existing regfile forwarding or stall timing.
- Reset asserted mid-operation drops the FIFO contents and `busy_o` immediately. Producers must also be reset.
- Throughput is one write per cycle. Sustained load + ALU traffic can starve the FIFO only while `ld_valid` is held continuously.

## Structure
- Shared package `fp_pkg`: `FLEN`, register index width (5), `wb_src_e` enum {WB_NONE, WB_LD, WB_ALU, WB_FPU}.
- One sub-module: `fp_wb_fifo` (parameterised sync FIFO, FLEN+5 wide, `full`/`empty` flags, pointer wrap via extra MSB).
- Arbiter, starvation counter, output register and scoreboard live in the top module.

## Test plan
- Reset: `rst_n`=0 mid-traffic → all outputs 0, `busy_o`=0, `fpu_ready`=1 next cycle after release.
- Simultaneous ld(f3, 0x3F800000), alu(f4), fpu(f5) at cycle 0 → writes f3 in cycle 1, f4 in cycle 2, f5 in cycle 3; `alu_ready`=0 in cycle 0.
- Fill FIFO with FPU f1, f2 while ALU streams continuously → `fpu_ready`=0 with FIFO full. After 4 lost cycles the head f1 is forced and `alu_ready`=0 that cycle.
- `issue_en` f7 at cycle 0, ALU result f7 granted at cycle 3 → `busy_o[7]`=1 in cycles 1–3, 0 from cycle 4.
- Same-cycle `issue_en` f9 and grant of f9 → `busy_o[9]` stays 1.
- Full FIFO, dequeue and `fpu_valid` in same cycle → no enqueue, no data loss, FIFO order preserved (FIFO_DEPTH=2, pointer wrap checked over 5 entries).

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP writeback types and constants: data width, register index width, writeback source tags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_pkg;

    localparam int FLEN     = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_LD,
        WB_ALU,
        WB_FPU
    } wb_src_e;

endpackage

// File: rtl/fp_wb_fifo.sv
// Small synchronous FIFO holding multi-cycle FPU results ({rd, data}) until they win the write port.
// Latency: an entry pushed at posedge N is visible at the head from cycle N+1.
// Backpressure: full flag is exported; a push while full is dropped here, so callers gate push with !full.
module fp_wb_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Storage needs no reset: the pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    // Pointer advance; reset empties the FIFO immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fp_writeback_arbiter.sv
// Picks one FP result per cycle for the regfile write port (load > starved FPU head > ALU > FPU head).
// Latency: 1 cycle from transfer to wr_en_o for load/ALU; FPU results add >=1 cycle through the FIFO.
// Backpressure: load never stalls; ALU stalls behind load or a forced FPU head; FPU stalls when FIFO full.
module fp_writeback_arbiter #(
    parameter int FLEN         = fp_pkg::FLEN,
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ld_valid,
    output logic                       ld_ready,
    input  logic [fp_pkg::REG_W-1:0]   ld_rd,
    input  logic [FLEN-1:0]            ld_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [fp_pkg::REG_W-1:0]   alu_rd,
    input  logic [FLEN-1:0]            alu_data,
    input  logic                       fpu_valid,
    output logic                       fpu_ready,
    input  logic [fp_pkg::REG_W-1:0]   fpu_rd,
    input  logic [FLEN-1:0]            fpu_data,
    input  logic                       issue_en,
    input  logic [fp_pkg::REG_W-1:0]   issue_rd,
    output logic [fp_pkg::NUM_REGS-1:0] busy_o,
    output logic                       wr_en_o,
    output logic [fp_pkg::REG_W-1:0]   wr_rd_o,
    output logic [FLEN-1:0]            wr_data_o
);

    import fp_pkg::*;

    localparam int ENTRY_W = FLEN + REG_W;
    localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = 1;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_head_dat;
    logic [REG_W-1:0]    head_rd;
    logic [FLEN-1:0]     head_data;
    logic [CNT_W-1:0]    starve_cnt;
    logic                starve_force;
    wb_src_e             grant_src;
    logic                grant_vld;
    logic [REG_W-1:0]    grant_rd;
    logic [FLEN-1:0]     grant_dat;
    logic [NUM_REGS-1:0] busy_nxt;

    fp_wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({fpu_rd, fpu_data}),
        .pop      (fifo_pop),
        .head_dat (fifo_head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign {head_rd, head_data} = fifo_head_dat;

    // A head that has lost STARVE_LIMIT times outranks the ALU (but never the load).
    assign starve_force = !fifo_empty && (starve_cnt == STARVE_MAX);

    // Readiness is deliberately not bypassed on a same-cycle dequeue when full.
    assign ld_ready  = 1'b1;
    assign alu_ready = !ld_valid && !starve_force;
    assign fpu_ready = !fifo_full;
    assign fifo_push = fpu_valid && fpu_ready;
    assign fifo_pop  = (grant_src == WB_FPU);
    assign grant_vld = (grant_src != WB_NONE);

    // Fixed-priority grant selection and the winning {rd, data}.
    always_comb begin
        grant_src = WB_NONE;
        grant_rd  = '0;
        grant_dat = '0;
        if (ld_valid) begin
            grant_src = WB_LD;
            grant_rd  = ld_rd;
            grant_dat = ld_data;
        end else if (starve_force) begin
            grant_src = WB_FPU;
            grant_rd  = head_rd;
            grant_dat = head_data;
        end else if (alu_valid) begin
            grant_src = WB_ALU;
            grant_rd  = alu_rd;
            grant_dat = alu_data;
        end else if (!fifo_empty) begin
            grant_src = WB_FPU;
            grant_rd  = head_rd;
            grant_dat = head_data;
        end
    end

    // Count consecutive lost cycles of a waiting head; saturates so a load-blocked head stays forced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + CNT_ONE;
        end
    end

    // Registered write port; rd/data hold their last value on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_o   <= 1'b0;
            wr_rd_o   <= '0;
            wr_data_o <= '0;
        end else begin
            wr_en_o <= grant_vld;
            if (grant_vld) begin
                wr_rd_o   <= grant_rd;
                wr_data_o <= grant_dat;
            end
        end
    end

    // Next pending-write mask: grant clears, issue sets, and the set is applied last so it wins.
    always_comb begin
        busy_nxt = busy_o;
        if (grant_vld) begin
            busy_nxt[grant_rd] = 1'b0;
        end
        if (issue_en) begin
            busy_nxt[issue_rd] = 1'b1;
        end
    end

    // Pending-write scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o <= '0;
        end else begin
            busy_o <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_fp_writeback_arbiter.sv
// Self-checking bench for fp_writeback_arbiter: vector table plus multi-cycle corner sequences.
// Latency: expected writes are queued in required order and matched as wr_en_o pulses appear.
// Backpressure: producers hold payload until valid && ready, as the real sources do.
module tb_fp_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid, ld_ready, alu_valid, alu_ready, fpu_valid, fpu_ready;
    logic [4:0]  ld_rd, alu_rd, fpu_rd, issue_rd, wr_rd_o;
    logic [31:0] ld_data, alu_data, fpu_data, wr_data_o, busy_o;
    logic        issue_en, wr_en_o;

    fp_writeback_arbiter #(
        .FLEN         (32),
        .FIFO_DEPTH   (2),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .fpu_valid (fpu_valid),
        .fpu_ready (fpu_ready),
        .fpu_rd    (fpu_rd),
        .fpu_data  (fpu_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .busy_o    (busy_o),
        .wr_en_o   (wr_en_o),
        .wr_rd_o   (wr_rd_o),
        .wr_data_o (wr_data_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        int          at;
    } item_t;

    typedef struct packed {
        logic       ld_v;
        logic [4:0] ld_rd;
        logic       alu_v;
        logic [4:0] alu_rd;
        logic       fpu_v;
        logic [4:0] fpu_rd;
        logic       exp_alu_rdy;
        logic       exp_fpu_rdy;
        logic       exp_wr_en;
        logic [4:0] exp_wr_rd;
    } vec_t;

    item_t ld_q[$], alu_q[$], fpu_q[$], exp_q[$];
    item_t mon_e;
    vec_t  vecs[8];
    int    cyc;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (cycle %0d): got %h, required %h", name, cyc, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [4:0] rd, input int at, input logic [3:0] tag);
        item_t r;
        logic [31:0] x;
        x = $urandom();
        r.rd = rd;
        r.data = {tag, x[27:0]};
        r.at = at;
        return r;
    endfunction

    function automatic vec_t mkv(input logic lv, input logic [4:0] lr, input logic av, input logic [4:0] ar,
                                 input logic fv, input logic [4:0] fr, input logic ear, input logic efr,
                                 input logic ewe, input logic [4:0] ewr);
        vec_t v;
        v.ld_v = lv; v.ld_rd = lr; v.alu_v = av; v.alu_rd = ar; v.fpu_v = fv; v.fpu_rd = fr;
        v.exp_alu_rdy = ear; v.exp_fpu_rdy = efr; v.exp_wr_en = ewe; v.exp_wr_rd = ewr;
        return v;
    endfunction

    // Present the head of each producer queue whose start cycle has arrived.
    task automatic drive();
        ld_valid = 1'b0; alu_valid = 1'b0; fpu_valid = 1'b0; issue_en = 1'b0;
        if (ld_q.size() > 0 && ld_q[0].at <= cyc) begin
            ld_valid = 1'b1; ld_rd = ld_q[0].rd; ld_data = ld_q[0].data;
        end
        if (alu_q.size() > 0 && alu_q[0].at <= cyc) begin
            alu_valid = 1'b1; alu_rd = alu_q[0].rd; alu_data = alu_q[0].data;
        end
        if (fpu_q.size() > 0 && fpu_q[0].at <= cyc) begin
            fpu_valid = 1'b1; fpu_rd = fpu_q[0].rd; fpu_data = fpu_q[0].data;
        end
    endtask

    task automatic start();
        @(negedge clk);
        cyc = 0;
        drive();
        #1;
    endtask

    // Advance one cycle: retire transferred items, then present the next cycle's inputs.
    task automatic tick();
        logic ld_go, alu_go, fpu_go;
        ld_go  = ld_valid && ld_ready;
        alu_go = alu_valid && alu_ready;
        fpu_go = fpu_valid && fpu_ready;
        @(posedge clk);
        if (ld_go)  ld_q.delete(0);
        if (alu_go) alu_q.delete(0);
        if (fpu_go) fpu_q.delete(0);
        cyc++;
        @(negedge clk);
        drive();
        #1;
    endtask

    // Scoreboard: every write pulse must match the next expected {rd, data}.
    always @(negedge clk) begin
        if (rst_n && wr_en_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", wr_rd_o, wr_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd", 32'(wr_rd_o), 32'(mon_e.rd));
                chk("wb_data", wr_data_o, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        item_t e, f1, f2;
        item_t a[7];

        vecs[0] = mkv(0, 0,  0, 0,  0, 0,  1, 1, 0, 0);
        vecs[1] = mkv(1, 1,  0, 0,  0, 0,  0, 1, 1, 1);
        vecs[2] = mkv(0, 0,  1, 2,  0, 0,  1, 1, 1, 2);
        vecs[3] = mkv(0, 0,  0, 0,  1, 3,  1, 1, 0, 0);
        vecs[4] = mkv(1, 4,  1, 5,  0, 0,  0, 1, 1, 4);
        vecs[5] = mkv(0, 0,  1, 6,  1, 7,  1, 1, 1, 6);
        vecs[6] = mkv(1, 8,  0, 0,  1, 9,  0, 1, 1, 8);
        vecs[7] = mkv(1, 0,  1, 31, 1, 16, 0, 1, 1, 0);

        cyc = 0;
        ld_valid = 0; alu_valid = 0; fpu_valid = 0; issue_en = 0;
        ld_rd = 0; alu_rd = 0; fpu_rd = 0; issue_rd = 0;
        ld_data = 0; alu_data = 0; fpu_data = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("rst_wr_rd", 32'(wr_rd_o), 32'd0);
        chk("rst_wr_data", wr_data_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_fpu_ready", 32'(fpu_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("ld_ready", 32'(ld_ready), 32'd1);
        ld_valid = 1'b1;
        #1;
        chk("rst_alu_ready_ld", 32'(alu_ready), 32'd0);
        ld_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: single-cycle patterns from an idle, empty state
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].ld_v) begin
                e = mk(vecs[i].ld_rd, 0, 4'h1); ld_q.push_back(e); exp_q.push_back(e);
            end
            if (vecs[i].alu_v) begin
                e = mk(vecs[i].alu_rd, 0, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
            end
            if (vecs[i].fpu_v) begin
                e = mk(vecs[i].fpu_rd, 0, 4'h3); fpu_q.push_back(e); exp_q.push_back(e);
            end
            start();
            chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(vecs[i].exp_alu_rdy));
            chk($sformatf("v%0d_fpu_ready", i), 32'(fpu_ready), 32'(vecs[i].exp_fpu_rdy));
            tick();
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en_o), 32'(vecs[i].exp_wr_en));
            if (vecs[i].exp_wr_en) begin
                chk($sformatf("v%0d_wr_rd", i), 32'(wr_rd_o), 32'(vecs[i].exp_wr_rd));
            end
            repeat (4) tick();
            chk($sformatf("v%0d_drained", i), 32'(exp_q.size()), 32'd0);
        end

        // Simultaneous load/ALU/FPU: writes in cycles 1, 2, 3
        e = mk(3, 0, 4'h1); e.data = 32'h3F800000; ld_q.push_back(e); exp_q.push_back(e);
        e = mk(4, 0, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
        e = mk(5, 0, 4'h3); fpu_q.push_back(e); exp_q.push_back(e);
        start();
        chk("sim_alu_ready_c0", 32'(alu_ready), 32'd0);
        tick();
        chk("sim_wr_en_c1", 32'(wr_en_o), 32'd1);
        chk("sim_wr_rd_c1", 32'(wr_rd_o), 32'd3);
        chk("sim_wr_data_c1", wr_data_o, 32'h3F800000);
        tick();
        chk("sim_wr_rd_c2", 32'(wr_rd_o), 32'd4);
        tick();
        chk("sim_wr_rd_c3", 32'(wr_rd_o), 32'd5);
        tick();
        chk("sim_drained", 32'(exp_q.size()), 32'd0);

        // Busy scoreboard: issue f7 at c0, ALU f7 granted at c3
        e = mk(7, 3, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
        start();
        issue_en = 1'b1; issue_rd = 5'd7;
        chk("busy7_c0", 32'(busy_o[7]), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("busy7_c%0d", c), 32'(busy_o[7]), 32'(c <= 3));
            if (c == 1) chk("busy_mask_c1", busy_o, 32'h0000_0080);
        end

        // Same-cycle issue and grant of f9: set wins
        e = mk(9, 1, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
        e = mk(9, 2, 4'h1); ld_q.push_back(e); exp_q.push_back(e);
        start();
        issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        chk("busy9_c1", 32'(busy_o[9]), 32'd1);
        issue_en = 1'b1; issue_rd = 5'd9;
        tick();
        chk("busy9_set_wins", 32'(busy_o[9]), 32'd1);
        tick();
        chk("busy9_cleared", 32'(busy_o[9]), 32'd0);
        repeat (2) tick();
        chk("busy_drained", 32'(exp_q.size()), 32'd0);

        // Starvation: ALU streams while FIFO holds f1, f2; f1 forced after 4 lost cycles
        for (int k = 0; k < 7; k++) begin
            a[k] = mk(5'(10 + k), 0, 4'h2);
            alu_q.push_back(a[k]);
        end
        f1 = mk(1, 0, 4'h3); f2 = mk(2, 0, 4'h3);
        fpu_q.push_back(f1); fpu_q.push_back(f2);
        for (int k = 0; k < 5; k++) exp_q.push_back(a[k]);
        exp_q.push_back(f1); exp_q.push_back(a[5]); exp_q.push_back(a[6]); exp_q.push_back(f2);
        start();
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("starve_alu_ready_c%0d", c), 32'(alu_ready), 32'((c == 5) ? 0 : 1));
            if (c == 2) chk("starve_fpu_ready_full", 32'(fpu_ready), 32'd0);
            if (c == 6) chk("starve_forced_rd", 32'(wr_rd_o), 32'd1);
            tick();
        end
        repeat (3) tick();
        chk("starve_drained", 32'(exp_q.size()), 32'd0);

        // Full FIFO with same-cycle dequeue and fpu_valid; 5 entries wrap the pointers
        e = mk(17, 0, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
        e = mk(18, 0, 4'h2); alu_q.push_back(e); exp_q.push_back(e);
        for (int k = 0; k < 5; k++) begin
            e = mk(5'(20 + k), 0, 4'h3); fpu_q.push_back(e); exp_q.push_back(e);
        end
        start();
        for (int c = 0; c < 9; c++) begin
            if (c == 2) chk("wrap_fpu_ready_full", 32'(fpu_ready), 32'd0);
            if (c == 3) chk("wrap_fpu_ready_after_deq", 32'(fpu_ready), 32'd1);
            if (c == 3) chk("wrap_e0_written", 32'(wr_rd_o), 32'd20);
            tick();
        end
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-traffic: FIFO contents and busy bits dropped at once
        for (int k = 0; k < 4; k++) begin
            e = mk(5'(26 + k), 0, 4'h2); alu_q.push_back(e);
        end
        exp_q.push_back(alu_q[0]); exp_q.push_back(alu_q[1]);
        e = mk(10, 0, 4'h3); fpu_q.push_back(e);
        e = mk(11, 0, 4'h3); fpu_q.push_back(e);
        start();
        issue_en = 1'b1; issue_rd = 5'd12;
        repeat (2) tick();
        rst_n = 1'b0;
        ld_q.delete(); alu_q.delete(); fpu_q.delete(); exp_q.delete();
        ld_valid = 0; alu_valid = 0; fpu_valid = 0; issue_en = 0;
        #1;
        chk("mid_rst_wr_en", 32'(wr_en_o), 32'd0);
        chk("mid_rst_wr_rd", 32'(wr_rd_o), 32'd0);
        chk("mid_rst_wr_data", wr_data_o, 32'd0);
        chk("mid_rst_busy", busy_o, 32'd0);
        chk("mid_rst_fpu_ready", 32'(fpu_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        start();
        chk("post_rst_fpu_ready", 32'(fpu_ready), 32'd1);
        chk("post_rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("post_rst_busy", busy_o, 32'd0);
        repeat (3) tick();
        chk("post_rst_no_stale_write", 32'(wr_en_o), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
